// File: rtl/max7219_refresh_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : max7219_refresh_ctrl_if
//  Description : Word handshake between the MAX7219 refresh sequencer and the
//                byte-pair SPI shifter. One transfer happens on every rising
//                clk edge where tx_valid && tx_ready.
//  Signals     : tx_valid - word available (sequencer -> shifter)
//                tx_ready - shifter accepts the word (shifter -> sequencer)
//                tx_addr  - MAX7219 register address
//                tx_data  - register data
//  Revision    : 1.0 - initial release
// ============================================================================
interface max7219_refresh_ctrl_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_addr;
  logic [7:0] tx_data;

  modport master (output tx_valid, output tx_addr, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_addr, input tx_data, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/max7219_refresh_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : max7219_refresh_ctrl
//  Description : MAX7219 8-digit display sequencer. Issues the five init
//                writes after reset, holds an 8-entry digit frame buffer,
//                refreshes it on a periodic tick and inserts host intensity
//                changes between digit words.
//  Ports       : clk        - system clock
//                reset      - synchronous, active-low reset
//                digit_we   - frame-buffer write strobe
//                digit_idx  - digit index 0..7 (register idx+1)
//                digit_val  - digit value
//                int_we     - intensity change request
//                int_val    - new intensity
//                tx         - word handshake to the SPI shifter (master)
//                busy       - high unless IDLE with nothing pending
//                init_done  - init sequence complete
//  Config      : MAX7219_DIRTY_SKIP_EN - when defined, SCAN sends only digits
//                whose dirty bit is set; otherwise every pass sends all 8.
//  Revision    : 1.0 - initial release
// ============================================================================
module max7219_refresh_ctrl #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter logic [2:0]  SCAN_LIMIT     = 3'd7,
  parameter logic [3:0]  INIT_INTENSITY = 4'hF,
  parameter logic [7:0]  DECODE         = 8'hFF
) (
  input  wire                    clk,
  input  wire                    reset,
  input  wire                    digit_we,
  input  wire  [2:0]             digit_idx,
  input  wire  [7:0]             digit_val,
  input  wire                    int_we,
  input  wire  [3:0]             int_val,
  max7219_refresh_ctrl_if.master tx,
  output logic                   busy,
  output logic                   init_done
);

`ifdef MAX7219_DIRTY_SKIP_EN
  localparam bit c_skip_en = 1'b1;
`else
  localparam bit c_skip_en = 1'b0;
`endif

  localparam int unsigned        c_cnt_w      = $clog2(REFRESH_DIV);
  localparam logic [c_cnt_w-1:0] c_cnt_reload = c_cnt_w'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_INTENS = 2'd2,
    ST_SCAN   = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_idx, w_idx_nxt;      // init step or scan index
  logic               r_resume, w_resume_nxt; // INTENS returns to SCAN
  logic               r_valid;
  logic [7:0]         r_addr, r_data;
  logic               r_busy, r_init_done;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_ref_pend, r_int_pend;
  logic [3:0]         r_int_val;
  logic [7:0]         r_buf [0:7];
  logic [7:0]         r_dirty;

  logic       w_tick, w_hs, w_load;
  logic [7:0] w_addr, w_data;
  logic       w_int_clr, w_ref_clr, w_done_set, w_dirty_clr;
  logic       w_int_pend_nxt, w_ref_pend_nxt;

  assign w_tick = (r_cnt == '0);
  assign w_hs   = r_valid && tx.tx_ready;

  // Tick/request set wins over a same-edge clear so no event is lost.
  assign w_int_pend_nxt = int_we | (r_int_pend & ~w_int_clr);
  assign w_ref_pend_nxt = w_tick | (r_ref_pend & ~w_ref_clr);

  // Decisions happen only at word boundaries: on a handshake (what follows
  // the word in flight) or in a load slot where no word is held.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_resume_nxt = r_resume;
    w_load       = 1'b0;
    w_addr       = 8'h00;
    w_data       = 8'h00;
    w_int_clr    = 1'b0;
    w_ref_clr    = 1'b0;
    w_done_set   = 1'b0;
    w_dirty_clr  = 1'b0;
    if (r_valid) begin
      if (w_hs) begin
        case (r_state)
          ST_INIT: begin
            if (r_idx == 3'd4) begin
              w_state_nxt = ST_SCAN;
              w_idx_nxt   = 3'd0;
              w_ref_clr   = 1'b1;
              w_done_set  = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 3'd1;
            end
          end
          ST_SCAN: begin
            w_dirty_clr = 1'b1;
            if (r_idx == 3'd7) begin
              w_state_nxt = ST_IDLE;
              w_idx_nxt   = 3'd0;
            end else begin
              w_idx_nxt = r_idx + 3'd1;
            end
          end
          ST_INTENS: w_state_nxt = r_resume ? ST_SCAN : ST_IDLE;
          default:   w_state_nxt = ST_IDLE;
        endcase
      end
    end else begin
      case (r_state)
        ST_INIT: begin
          w_load = 1'b1;
          case (r_idx)
            3'd0:    begin w_addr = 8'h0F; w_data = 8'h00;                  end
            3'd1:    begin w_addr = 8'h0C; w_data = 8'h01;                  end
            3'd2:    begin w_addr = 8'h0B; w_data = {5'b0, SCAN_LIMIT};     end
            3'd3:    begin w_addr = 8'h0A; w_data = {4'b0, INIT_INTENSITY}; end
            default: begin w_addr = 8'h09; w_data = DECODE;                 end
          endcase
        end
        ST_IDLE: begin
          if (r_int_pend) begin
            w_load       = 1'b1;
            w_addr       = 8'h0A;
            w_data       = {4'b0, r_int_val};
            w_int_clr    = 1'b1;
            w_resume_nxt = 1'b0;
            w_state_nxt  = ST_INTENS;
          end else if (r_ref_pend) begin
            w_state_nxt = ST_SCAN;
            w_idx_nxt   = 3'd0;
            w_ref_clr   = 1'b1;
          end
        end
        ST_SCAN: begin
          if (r_int_pend) begin
            // Yield to the intensity word; r_idx already points at the
            // next digit so the pass resumes where it left off.
            w_load       = 1'b1;
            w_addr       = 8'h0A;
            w_data       = {4'b0, r_int_val};
            w_int_clr    = 1'b1;
            w_resume_nxt = 1'b1;
            w_state_nxt  = ST_INTENS;
          end else if (c_skip_en && !r_dirty[r_idx]) begin
            if (r_idx == 3'd7) begin
              w_state_nxt = ST_IDLE;
              w_idx_nxt   = 3'd0;
            end else begin
              w_idx_nxt = r_idx + 3'd1;
            end
          end else begin
            w_load = 1'b1;
            w_addr = {5'b0, r_idx} + 8'd1;
            w_data = r_buf[r_idx];
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_INIT;
      r_idx       <= 3'd0;
      r_resume    <= 1'b0;
      r_valid     <= 1'b0;
      r_addr      <= 8'h00;
      r_data      <= 8'h00;
      r_busy      <= 1'b0;
      r_init_done <= 1'b0;
      r_cnt       <= c_cnt_reload;
      r_ref_pend  <= 1'b0;
      r_int_pend  <= 1'b0;
      r_int_val   <= 4'h0;
      r_dirty     <= 8'hFF;
      for (int i = 0; i < 8; i++) r_buf[i] <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_resume   <= w_resume_nxt;
      r_ref_pend <= w_ref_pend_nxt;
      r_int_pend <= w_int_pend_nxt;
      r_busy     <= !(w_state_nxt == ST_IDLE && !w_int_pend_nxt && !w_ref_pend_nxt);
      r_cnt      <= w_tick ? c_cnt_reload : r_cnt - 1'b1;

      // The word is captured here, so later buffer writes cannot alter it.
      if (w_load) begin
        r_valid <= 1'b1;
        r_addr  <= w_addr;
        r_data  <= w_data;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end

      if (w_done_set) r_init_done <= 1'b1;
      if (int_we)     r_int_val   <= int_val;

      // A write on the handshake edge of the same digit keeps it dirty.
      if (w_dirty_clr) r_dirty[r_idx] <= 1'b0;
      if (digit_we) begin
        r_dirty[digit_idx] <= 1'b1;
        r_buf[digit_idx]   <= digit_val;
      end
    end
  end

  assign tx.tx_valid = r_valid;
  assign tx.tx_addr  = r_addr;
  assign tx.tx_data  = r_data;
  assign busy        = r_busy;
  assign init_done   = r_init_done;

endmodule
`default_nettype wire
